// File: rtl/arith_sched_pkg.sv
// Shared types and constants for the arithmetic issue scheduler.
// FU arithmetic_type encodings, width helpers and the writeback entry layout.
package arith_sched_pkg;

  localparam logic [2:0] ARITH_ADDSUB = 3'b000;
  localparam logic [2:0] ARITH_SLT    = 3'b010;
  localparam logic [2:0] ARITH_SLTU   = 3'b011;

  function automatic int robw(input int rob_size);
    return (rob_size > 1) ? $clog2(rob_size) : 1;
  endfunction

  function automatic int tagw(input int phys_reg_size);
    return (phys_reg_size > 1) ? $clog2(phys_reg_size) : 1;
  endfunction

  localparam int XLEN_DEF = 32;
  localparam int ROBW_DEF = robw(256);
  localparam int TAGW_DEF = tagw(256);

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [ROBW_DEF-1:0] rob;
    logic [TAGW_DEF-1:0] tag;
  } wb_entry_t;

endpackage

// File: rtl/arith_issue_sched_wb_fifo.sv
// Writeback FIFO between the FU and the CDB; head outputs read zero while empty.
// Flush empties the queue and drops any push arriving on the same edge.
module arith_wb_fifo
  import arith_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(wb_entry_t),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;
  assign head_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign do_pop      = pop_i && valid_o;
  assign do_push     = push_i && ((count_q < CW'(DEPTH)) || do_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/arith_issue_sched.sv
// Round-robin issue scheduler for one arithmetic FU with credit-based writeback.
// Optional ARITH_SCHED_STATS_EN adds stat_issued/stat_stall counters.
module arith_issue_sched
  import arith_sched_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ROB_SIZE      = 256,
  parameter int PHYS_REG_SIZE = 256,
  parameter int NUM_REQ       = 4,
  parameter int WB_DEPTH      = 4,
  localparam int ROBW         = robw(ROB_SIZE),
  localparam int TAGW         = tagw(PHYS_REG_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_type,
  input  logic [NUM_REQ-1:0]       req_info,
  input  logic [ROBW*NUM_REQ-1:0]  req_rob,
  input  logic [TAGW*NUM_REQ-1:0]  req_tag,
  input  logic [XLEN*NUM_REQ-1:0]  req_rs1,
  input  logic [XLEN*NUM_REQ-1:0]  req_rs2,
  output logic                     fu_valid_in,
  output logic [2:0]               fu_type,
  output logic                     fu_info,
  output logic [XLEN-1:0]          fu_rs1,
  output logic [XLEN-1:0]          fu_rs2,
  input  logic [XLEN-1:0]          fu_result,
  input  logic                     fu_valid_out,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [XLEN-1:0]          wb_result,
  output logic [ROBW-1:0]          wb_rob,
  output logic [TAGW-1:0]          wb_tag
`ifdef ARITH_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stall
`endif
);

  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(WB_DEPTH + 1);
  localparam int EW   = XLEN + ROBW + TAGW;

  logic [2:0]      type_a [NUM_REQ];
  logic [ROBW-1:0] rob_a  [NUM_REQ];
  logic [TAGW-1:0] tag_a  [NUM_REQ];
  logic [XLEN-1:0] rs1_a  [NUM_REQ];
  logic [XLEN-1:0] rs2_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign type_a[g] = req_type[3*g +: 3];
    assign rob_a[g]  = req_rob[ROBW*g +: ROBW];
    assign tag_a[g]  = req_tag[TAGW*g +: TAGW];
    assign rs1_a[g]  = req_rs1[XLEN*g +: XLEN];
    assign rs2_a[g]  = req_rs2[XLEN*g +: XLEN];
  end

  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
  logic            fu_valid_in_q, s2_valid_q;
  logic [2:0]      fu_type_q;
  logic            fu_info_q;
  logic [XLEN-1:0] fu_rs1_q, fu_rs2_q;
  logic [ROBW-1:0] s1_rob_q, s2_rob_q;
  logic [TAGW-1:0] s1_tag_q, s2_tag_q;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     used;
  logic            credit_ok, grant, found;
  logic [PTRW-1:0] gnt_idx, scan_idx;
  logic [PTRW:0]   scan_sum;
  logic            push, pop;
  logic [EW-1:0]   head_data;

  // Credit counts only registered state, so a pop this cycle frees a slot next cycle.
  assign used      = (CW+1)'(fifo_count) + (CW+1)'(fu_valid_in_q) + (CW+1)'(s2_valid_q);
  assign credit_ok = used < (CW+1)'(WB_DEPTH);

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTRW+1)'(i);
      if (scan_sum >= (PTRW+1)'(NUM_REQ)) scan_sum = scan_sum - (PTRW+1)'(NUM_REQ);
      scan_idx = scan_sum[PTRW-1:0];
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    grant     = rst && !flush && credit_ok && found;
    req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    rr_ptr_d  = rr_ptr_q;
    if (grant) rr_ptr_d = (gnt_idx == PTRW'(NUM_REQ - 1)) ? '0 : gnt_idx + PTRW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      fu_valid_in_q <= 1'b0;
      s2_valid_q    <= 1'b0;
      fu_type_q     <= '0;
      fu_info_q     <= 1'b0;
      fu_rs1_q      <= '0;
      fu_rs2_q      <= '0;
      s1_rob_q      <= '0;
      s1_tag_q      <= '0;
      s2_rob_q      <= '0;
      s2_tag_q      <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      fu_valid_in_q <= grant;
      s2_valid_q    <= flush ? 1'b0 : fu_valid_in_q;
      if (grant) begin
        fu_type_q <= type_a[gnt_idx];
        fu_info_q <= req_info[gnt_idx];
        fu_rs1_q  <= rs1_a[gnt_idx];
        fu_rs2_q  <= rs2_a[gnt_idx];
        s1_rob_q  <= rob_a[gnt_idx];
        s1_tag_q  <= tag_a[gnt_idx];
      end
      s2_rob_q <= s1_rob_q;
      s2_tag_q <= s1_tag_q;
    end
  end

  assign fu_valid_in = fu_valid_in_q;
  assign fu_type     = fu_type_q;
  assign fu_info     = fu_info_q;
  assign fu_rs1      = fu_rs1_q;
  assign fu_rs2      = fu_rs2_q;

  // A result the FU emits after a flush has no matching S2 entry and is ignored.
  assign push = s2_valid_q && fu_valid_out;
  assign pop  = wb_valid && wb_ready;

  arith_wb_fifo #(
    .DEPTH (WB_DEPTH),
    .W     (EW)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({fu_result, s2_rob_q, s2_tag_q}),
    .pop_i       (pop),
    .head_data_o (head_data),
    .valid_o     (wb_valid),
    .count_o     (fifo_count)
  );

  assign {wb_result, wb_rob, wb_tag} = head_data;

`ifdef ARITH_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant) stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !flush && !credit_ok) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arith_issue_sched.sv
// Bench for arith_issue_sched: FU model plus a grant/writeback scoreboard.
module tb_arith_issue_sched;

  logic        clk = 1'b0;
  logic        rst, flush, wb_ready;
  logic [3:0]  req_valid, req_ready, req_info;
  logic [11:0] req_type;
  logic [31:0] req_rob, req_tag;
  logic [127:0] req_rs1, req_rs2;
  logic        fu_valid_in, fu_info, fu_valid_out, wb_valid;
  logic [2:0]  fu_type;
  logic [31:0] fu_rs1, fu_rs2, fu_result, wb_result;
  logic [7:0]  wb_rob, wb_tag;
`ifdef ARITH_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  logic [2:0]  rq_type [4];
  logic        rq_info [4];
  logic [31:0] rq_rs1  [4];
  logic [31:0] rq_rs2  [4];
  logic [7:0]  rq_rob  [4];
  logic [7:0]  rq_tag  [4];

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_type[3*g +: 3]  = rq_type[g];
    assign req_info[g]         = rq_info[g];
    assign req_rs1[32*g +: 32] = rq_rs1[g];
    assign req_rs2[32*g +: 32] = rq_rs2[g];
    assign req_rob[8*g +: 8]   = rq_rob[g];
    assign req_tag[8*g +: 8]   = rq_tag[g];
  end

  arith_issue_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_info(req_info),
    .req_rob(req_rob), .req_tag(req_tag), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .fu_valid_in(fu_valid_in), .fu_type(fu_type), .fu_info(fu_info), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
    .fu_result(fu_result), .fu_valid_out(fu_valid_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_rob(wb_rob), .wb_tag(wb_tag)
`ifdef ARITH_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(logic [2:0] t, logic inf, logic [31:0] a, logic [31:0] b);
    case (t)
      3'b000:  return inf ? a - b : a + b;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd2;
    endcase
  endfunction

  // Functional unit: one-cycle latency, no knowledge of flush.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fu_valid_out <= 1'b0;
      fu_result    <= '0;
    end else begin
      fu_valid_out <= fu_valid_in;
      fu_result    <= ref_op(fu_type, fu_info, fu_rs1, fu_rs2);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every granted op not yet popped, in grant order, with the edge it becomes visible.
  typedef struct {
    logic [47:0] ent;
    int          vis;
  } exp_t;
  exp_t        sbq[$];
  int          rr = 0;
  int          edge_cnt = 0;
  logic        last_grant = 1'b0;
  logic [67:0] last_ops = '0;
  logic [47:0] obs_d[$];
  int          obs_t[$];
  int          g_cnt_obs = 0;
  int          gcount = 0;

  task automatic run_cycle();
    int   eg;
    logic [3:0] exp_ready;
    logic exp_wbv;
    exp_t e;
    #1;
    eg = -1;
    if (rst && !flush && sbq.size() < 4)
      for (int k = 0; k < 4; k++)
        if (eg < 0 && req_valid[(rr + k) % 4]) eg = (rr + k) % 4;
    exp_ready = (eg >= 0) ? (4'b0001 << eg) : 4'b0000;
    chk("req_ready", req_ready, exp_ready);
    chk("fu_valid_in", fu_valid_in, last_grant);
    if (last_grant) chk("fu_ops", {fu_type, fu_info, fu_rs1, fu_rs2}, last_ops);
    exp_wbv = (sbq.size() > 0) && (sbq[0].vis <= edge_cnt);
    chk("wb_valid", wb_valid, exp_wbv);
    if (exp_wbv) chk("wb_entry", {wb_result, wb_rob, wb_tag}, sbq[0].ent);
    if (req_ready != 0) begin
      g_cnt_obs = edge_cnt;
      gcount++;
    end
    if (wb_valid && wb_ready) begin
      obs_d.push_back({wb_result, wb_rob, wb_tag});
      obs_t.push_back(edge_cnt);
    end
    @(posedge clk);
    edge_cnt++;
    if (exp_wbv && wb_ready) void'(sbq.pop_front());
    if (flush || !rst) sbq.delete();
    if (!rst) rr = 0;
    last_grant = 1'b0;
    if (eg >= 0) begin
      e.ent = {ref_op(rq_type[eg], rq_info[eg], rq_rs1[eg], rq_rs2[eg]), rq_rob[eg], rq_tag[eg]};
      e.vis = edge_cnt + 2;
      sbq.push_back(e);
      rr = (eg + 1) % 4;
      last_grant = 1'b1;
      last_ops = {rq_type[eg], rq_info[eg], rq_rs1[eg], rq_rs2[eg]};
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] t, input logic inf,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] rob, input logic [7:0] tag);
    rq_type[i] = t; rq_info[i] = inf; rq_rs1[i] = a; rq_rs2[i] = b;
    rq_rob[i] = rob; rq_tag[i] = tag;
  endtask

  function automatic logic [2:0] rand_type();
    case ($urandom_range(0, 4))
      0: return 3'b000;
      1: return 3'b010;
      2: return 3'b011;
      3: return 3'b111;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < 4; i++)
      set_req(i, rand_type(), 1'($urandom_range(0, 1)), $urandom, $urandom,
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wb_ready = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, 3'b000, 1'b0, 32'(i), 32'(i + 1), 8'(i), 8'(i + 4));
    #1;
    chk("reset_fu_valid_in", fu_valid_in, 1'b0);
    chk("reset_req_ready", req_ready, 4'b0000);
    chk("reset_wb", {wb_valid, wb_result, wb_rob, wb_tag}, 49'd0);
    chk("reset_fu_regs", {fu_type, fu_info, fu_rs1, fu_rs2}, 68'd0);
    @(negedge clk);
    run_cycle(); run_cycle();
    rst = 1'b1; req_valid = 4'h0;
    run_cycle();

    // Single add on requester 0
    obs_d.delete(); obs_t.delete();
    set_req(0, 3'b000, 1'b0, 32'd5, 32'd7, 8'd3, 8'd9);
    req_valid = 4'b0001;
    run_cycle();
    req_valid = 4'b0000;
    repeat (5) run_cycle();
    chk("single_count", obs_d.size(), 1);
    chk("single_entry", obs_d[0], {32'd12, 8'd3, 8'd9});
    chk("single_latency", obs_t[0] - g_cnt_obs, 3);

    // All requesters continuously valid
    req_valid = 4'hF;
    repeat (12) begin randomize_reqs(); run_cycle(); end
    req_valid = 4'h0;
    repeat (4) run_cycle();

    // Backpressure: exactly WB_DEPTH grants, then release
    wb_ready = 1'b0; req_valid = 4'hF; gcount = 0;
    repeat (8) begin randomize_reqs(); run_cycle(); end
    chk("credit_grants", gcount, 4);
    wb_ready = 1'b1;
    repeat (6) run_cycle();
    req_valid = 4'h0;
    repeat (6) run_cycle();

    // Directed arithmetic types
    obs_d.delete(); obs_t.delete();
    set_req(1, 3'b000, 1'b1, 32'd1, 32'd2, 8'd10, 8'd20);
    req_valid = 4'b0010; run_cycle();
    set_req(2, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd0, 8'd11, 8'd21);
    req_valid = 4'b0100; run_cycle();
    set_req(3, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd0, 8'd12, 8'd22);
    req_valid = 4'b1000; run_cycle();
    set_req(0, 3'b111, 1'b0, 32'd100, 32'd50, 8'd13, 8'd23);
    req_valid = 4'b0001; run_cycle();
    req_valid = 4'b0000;
    repeat (5) run_cycle();
    chk("arith_count", obs_d.size(), 4);
    chk("arith_sub", obs_d[0], {32'hFFFFFFFF, 8'd10, 8'd20});
    chk("arith_slt", obs_d[1], {32'd1, 8'd11, 8'd21});
    chk("arith_sltu", obs_d[2], {32'd0, 8'd12, 8'd22});
    chk("arith_unsup", obs_d[3], {32'd2, 8'd13, 8'd23});

    // Flush with two in flight and two queued
    wb_ready = 1'b0; req_valid = 4'hF;
    repeat (4) begin randomize_reqs(); run_cycle(); end
    req_valid = 4'h0; flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    chk("flush_wb_valid", wb_valid, 1'b0);
    repeat (4) run_cycle();
    wb_ready = 1'b1; obs_d.delete(); obs_t.delete();
    set_req(2, 3'b000, 1'b0, 32'd40, 32'd2, 8'd77, 8'd88);
    req_valid = 4'b0100;
    run_cycle();
    req_valid = 4'h0;
    repeat (5) run_cycle();
    chk("post_flush_count", obs_d.size(), 1);
    chk("post_flush_entry", obs_d[0], {32'd42, 8'd77, 8'd88});

    // Random traffic
    repeat (400) begin
      randomize_reqs();
      req_valid = 4'($urandom_range(0, 15));
      wb_ready  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      run_cycle();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream
    wb_ready = 1'b0; req_valid = 4'hF;
    repeat (4) begin randomize_reqs(); run_cycle(); end
    #2 rst = 1'b0;
    #1;
    chk("async_fu_valid_in", fu_valid_in, 1'b0);
    chk("async_wb_valid", wb_valid, 1'b0);
    chk("async_req_ready", req_ready, 4'b0000);
    sbq.delete(); rr = 0; last_grant = 1'b0;
    @(negedge clk);
    run_cycle();
    rst = 1'b1; wb_ready = 1'b1;
    run_cycle();
    chk("post_reset_fu_rob", {fu_valid_in, dut.s1_rob_q == rq_rob[0]}, 2'b11);
    repeat (8) begin randomize_reqs(); run_cycle(); end
    req_valid = 4'h0;
    repeat (6) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
